// File: rtl/score_pkg.sv
// Shared types and constants for the score display controller.
// Segment codes are active-low, bit0 = a ... bit6 = g.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int BLINK_CYCLES_DEF = 25000000;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/score_display_ctrl_seg7.sv
// BCD digit to active-low seven-segment pattern.
// Non-decimal codes light nothing.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; codes 10..15 blank the digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to BCD (shift-and-add-3) with 3-digit 7-seg
// display, leading-zero blanking and game-over blinking.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  score_in,
  input  logic        score_valid,
  output logic        score_ready,
  input  logic        blank_lz,
  input  logic        game_over,
  output logic [11:0] bcd_out,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  localparam int CW =
    (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  state_t state, next;
  logic [7:0]    shreg;
  logic [11:0]   scratch;
  logic [11:0]   adj;
  logic [2:0]    cnt;
  logic          accept;
  logic [CW-1:0] blink_cnt;
  logic          phase;
  logic [6:0]    seg2, seg1, seg0;
  logic          hz, tz;

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next;
  end

  // Next state and handshake
  always_comb begin
    next        = state;
    score_ready = 1'b0;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        score_ready = 1'b1;
        accept      = score_valid;
        if (score_valid) next = CONV;
      end
      CONV:    if (cnt == 3'd7) next = LATCH;
      LATCH:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Add-3 correction on each BCD nibble before shifting
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  // Conversion datapath and result latch
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_out <= '0;
    end else begin
      if (accept) begin
        shreg   <= score_in;
        scratch <= '0;
        cnt     <= '0;
      end else if (state == CONV) begin
        scratch <= {adj[10:0], shreg[7]};
        shreg   <= {shreg[6:0], 1'b0};
        cnt     <= cnt + 3'd1;
      end else if (state == LATCH) begin
        bcd_out <= scratch;
      end
    end
  end

  // Blink half-period counter, cleared when not game over
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!game_over) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  seg7_decode u_d2 (.bcd(bcd_out[11:8]), .seg(seg2));
  seg7_decode u_d1 (.bcd(bcd_out[7:4]),  .seg(seg1));
  seg7_decode u_d0 (.bcd(bcd_out[3:0]),  .seg(seg0));

  // Leading-zero and blink masking of the digit patterns
  always_comb begin
    hz   = (bcd_out[11:8] == 4'd0);
    tz   = (bcd_out[7:4] == 4'd0);
    HEX2 = seg2;
    HEX1 = seg1;
    HEX0 = seg0;
    if (blank_lz && hz)       HEX2 = SEG_BLANK;
    if (blank_lz && hz && tz) HEX1 = SEG_BLANK;
    if (phase) begin
      HEX2 = SEG_BLANK;
      HEX1 = SEG_BLANK;
      HEX0 = SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl.
// Blink half-period shortened to 4 cycles.
module tb_score_display_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [7:0]  score_in;
  logic        score_valid;
  logic        score_ready;
  logic        blank_lz;
  logic        game_over;
  logic [11:0] bcd_out;
  logic [6:0]  HEX2, HEX1, HEX0;

  int errors = 0;
  int checks = 0;
  logic [11:0] last_bcd = 12'h000;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  always #5 CLOCK_50 = ~CLOCK_50;

  score_display_ctrl #(.BLINK_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .score_in(score_in),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .blank_lz(blank_lz),
    .game_over(game_over),
    .bcd_out(bcd_out),
    .HEX2(HEX2),
    .HEX1(HEX1),
    .HEX0(HEX0)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    score_in = 8'd0;
    score_valid = 1'b0;
    blank_lz = 1'b0;
    game_over = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_bcd got %h want 000", bcd_out);
    end
    checks++;
    if (score_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", score_ready);
    end
    checks++;
    if ({HEX2, HEX1, HEX0} !== {S0, S0, S0}) begin
      errors++;
      $display("FAIL reset_hex got %b %b %b want %b %b %b",
               HEX2, HEX1, HEX0, S0, S0, S0);
    end
    blank_lz = 1'b1;
    #1;
    checks++;
    if ({HEX2, HEX1, HEX0} !== {SB, SB, S0}) begin
      errors++;
      $display("FAIL reset_hex_lz got %b %b %b want %b %b %b",
               HEX2, HEX1, HEX0, SB, SB, S0);
    end
    tick();
    tick();
    resetn = 1'b1;
    blank_lz = 1'b0;
    tick();
    checks++;
    if (bcd_out !== 12'h000 || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got bcd=%h rdy=%b want 000 1",
               bcd_out, score_ready);
    end
  endtask

  task automatic test_score(input string name,
                            input logic [7:0] v,
                            input logic [11:0] exp,
                            input logic blz,
                            input logic [6:0] e2,
                            input logic [6:0] e1,
                            input logic [6:0] e0);
    int n;
    blank_lz = blz;
    n = 0;
    while (score_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (score_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready got %b want 1", name, score_ready);
    end
    score_in = v;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    score_in = ~v;
    checks++;
    if (score_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %b want 0", name, score_ready);
    end
    repeat (8) tick();
    checks++;
    if (bcd_out !== last_bcd || score_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_early got bcd=%h rdy=%b want %h 0",
               name, bcd_out, score_ready, last_bcd);
    end
    tick();
    last_bcd = exp;
    checks++;
    if (bcd_out !== exp || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_bcd got bcd=%h rdy=%b want %h 1",
               name, bcd_out, score_ready, exp);
    end
    checks++;
    if ({HEX2, HEX1, HEX0} !== {e2, e1, e0}) begin
      errors++;
      $display("FAIL %s_hex got %b %b %b want %b %b %b",
               name, HEX2, HEX1, HEX0, e2, e1, e0);
    end
  endtask

  task automatic test_back_to_back();
    blank_lz = 1'b0;
    score_in = 8'd10;
    score_valid = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      score_in = 8'(i * 29);
      tick();
    end
    score_in = 8'd99;
    tick();
    checks++;
    if (bcd_out !== 12'h010 || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got bcd=%h rdy=%b want 010 1",
               bcd_out, score_ready);
    end
    tick();
    score_valid = 1'b0;
    score_in = 8'd3;
    checks++;
    if (score_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept got rdy=%b want 0", score_ready);
    end
    repeat (9) tick();
    last_bcd = 12'h099;
    checks++;
    if (bcd_out !== 12'h099 || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got bcd=%h rdy=%b want 099 1",
               bcd_out, score_ready);
    end
  endtask

  task automatic test_blink();
    logic [20:0] on;
    logic [6:0] s;
    on = {S0, S9, S9};
    game_over = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      tick();
      s = 7'(e);
      if (e == 1 || e == 3 || e == 4 || e == 7 ||
          e == 8 || e == 12) begin
        checks++;
        if ((((e - 1) / 4) % 2 == 0) ? 1'b0 : 1'b0) ;
        if ({HEX2, HEX1, HEX0} !==
            (((e / 4) % 2 == 1) ? {SB, SB, SB} : on)) begin
          errors++;
          $display("FAIL blink_e%0d got %b %b %b", s,
                   HEX2, HEX1, HEX0);
        end
      end
    end
    game_over = 1'b0;
    tick();
    checks++;
    if ({HEX2, HEX1, HEX0} !== on) begin
      errors++;
      $display("FAIL blink_stop got %b %b %b want %b %b %b",
               HEX2, HEX1, HEX0, S0, S9, S9);
    end
    repeat (5) tick();
    checks++;
    if ({HEX2, HEX1, HEX0} !== on) begin
      errors++;
      $display("FAIL blink_steady got %b %b %b want %b %b %b",
               HEX2, HEX1, HEX0, S0, S9, S9);
    end
  endtask

  task automatic test_reset_mid_conv();
    blank_lz = 1'b0;
    score_in = 8'd200;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (bcd_out !== 12'h000 || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_now got bcd=%h rdy=%b want 000 1",
               bcd_out, score_ready);
    end
    tick();
    tick();
    resetn = 1'b1;
    last_bcd = 12'h000;
    repeat (12) tick();
    checks++;
    if (bcd_out !== 12'h000 || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after got bcd=%h rdy=%b want 000 1",
               bcd_out, score_ready);
    end
    test_score("after_rst", 8'd128, 12'h128, 1'b0, S1, S2, 7'b0000000);
  endtask

  initial begin
    test_reset();
    test_score("s173", 8'd173, 12'h173, 1'b0, S1, S7, S3);
    test_score("s255", 8'd255, 12'h255, 1'b0, S2, S5, S5);
    test_score("s0", 8'd0, 12'h000, 1'b1, SB, SB, S0);
    test_score("s7", 8'd7, 12'h007, 1'b1, SB, SB, S7);
    test_score("s40", 8'd40, 12'h040, 1'b1, SB, S4, S0);
    test_back_to_back();
    test_blink();
    test_reset_mid_conv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
